regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instr_valid  in  1  retire request from execute
- ready  out  1  block can accept a request this cycle
- instr  in  32  retiring instruction; opcode [6:0], funct3 [14:12], rd [11:7]
- alu_result  in  32  ALU output; this is the load address for loads
- pc_plus4  in  32  link value for JAL/JALR
- mem_req  out  1  data-memory read request
- mem_addr  out  32  word-aligned read address
- mem_rdata  in  32  read data
- mem_rvalid  in  1  read data valid
- write_en_3  out  1  register-file write strobe
- rd_addr  out  5  register-file destination
- write_data  out  32  register-file write data
- misalign_err  out  1  one-cycle pulse: misaligned load dropped
- illegal_err  out  1  one-cycle pulse: illegal load funct3 dropped

Function
REQ-002 A request SHALL be accepted only in a cycle where instr_valid=1 and ready=1; instr_valid while ready=0 SHALL be ignored (no buffering).
REQ-003 The FSM SHALL have states IDLE, LOAD_WAIT, and LOAD_WB; ready SHALL be 1 only in IDLE.
REQ-004 Result source SHALL be selected by opcode:
- 0110011, 0010011, 0110111, 0010111: alu_result
- 1101111, 1100111: pc_plus4
- 0000011: memory
- all others: no write
REQ-005 For a non-load accepted in IDLE: write_en_3=1 on the next cycle, with rd_addr=instr[11:7] and write_data as selected; the FSM stays in IDLE.
REQ-006 write_en_3 SHALL never assert when rd=0; the cycle still completes normally.
REQ-007 For an accepted load with legal funct3 and aligned address: IDLE->LOAD_WAIT; from the next cycle, hold mem_req=1 and mem_addr={alu_result[31:2],2'b00}.
REQ-008 Latched rd, funct3, and addr[1:0] SHALL be held until the load writes back.
REQ-009 In LOAD_WAIT, mem_req SHALL stay 1 until the cycle mem_rvalid=1.
REQ-010 On mem_rvalid=1: capture mem_rdata, go to LOAD_WB, deassert mem_req next cycle.
REQ-011 mem_rvalid while not in LOAD_WAIT SHALL be ignored.
REQ-012 In LOAD_WB: write_en_3=1 (unless rd=0) with extracted data for one cycle, then return to IDLE. Load-to-write latency is 1 cycle after mem_rvalid.
REQ-013 Extraction SHALL use latched addr[1:0]:
- LB (000) / LBU (100): byte at bits [8*a+7:8*a], sign- / zero-extended
- LH (001) / LHU (101): half at bits [16*a[1]+15:16*a[1]], sign- / zero-extended
- LW (010): full word
REQ-014 A load with funct3 in {011, 110, 111} SHALL stay in IDLE, perform no write and no mem_req, and pulse illegal_err for one cycle the cycle after acceptance.
REQ-015 Misalignment (LH/LHU with addr[0]=1, or LW with addr[1:0]!=0) SHALL stay in IDLE, perform no write and no mem_req, and pulse misalign_err for one cycle the cycle after acceptance.
REQ-016 Back-to-back non-loads SHALL sustain one write per cycle; write_en_3 is a one-cycle pulse per request.
REQ-017 All outputs except ready SHALL be registered.

Reset
REQ-018 While reset=1 at a clock edge: state=IDLE, write_en_3=0, mem_req=0, misalign_err=0, illegal_err=0, rd_addr=0, write_data=0, mem_addr=0.
REQ-019 reset SHALL take priority over instr_valid and mem_rvalid in the same cycle.
REQ-020 Reset during LOAD_WAIT or LOAD_WB SHALL abandon the load with no write, and mem_req SHALL be 0 the next cycle.
REQ-021 ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-022 ADDI x5 (0x00A28293), alu_result=0x0000000F -> next cycle write_en_3=1, rd_addr=5, write_data=0x0000000F.
REQ-023 JAL x1, pc_plus4=0x00000104 -> write_data=0x00000104, rd_addr=1; the same request with rd=0 -> write_en_3 stays 0.
REQ-024 LB x7, alu_result=0x00000103, mem_rvalid after 3 cycles with mem_rdata=0x80FF1234 -> mem_addr=0x00000100 for 3 cycles, then write_data=0xFFFFFF80 to rd 7; with LBU the data is 0x00000080.
REQ-025 LW with alu_result=0x00000102 -> misalign_err pulses 1 cycle, no mem_req, no write; funct3=011 -> illegal_err pulses, no write.
REQ-026 reset asserted in LOAD_WAIT with mem_rvalid=1 in the same cycle -> no write_en_3 ever, mem_req=0 next cycle, ready=1 after reset release.
REQ-027 Three back-to-back ADDs followed by a load issued while ready=0 -> three consecutive write pulses, and the blocked request is ignored.

Source files
------------

// File: rtl/regfile_writeback.sv
// Register-file writeback stage. Retiring ALU/link results are written one
// cycle after acceptance; loads issue a word-aligned read, wait for the
// memory response and write the extracted, extended value back.
//
// Handshake: a request transfers on a rising edge where instr_valid=1 and
// ready=1. ready is high only while the FSM is idle, and a request offered
// while ready=0 is dropped, never buffered. mem_req stays high until the
// edge that samples mem_rvalid=1, and mem_rvalid is ignored at any other time.
module regfile_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        ready,
  input  logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] pc_plus4,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        write_en_3,
  output logic [4:0]  rd_addr,
  output logic [31:0] write_data,
  output logic        misalign_err,
  output logic        illegal_err
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    LOAD_WB   = 2'd2
  } state_t;

  state_t     state;
  logic [4:0] lat_rd;
  logic [2:0] lat_funct3;
  logic [1:0] lat_off;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign unused_instr_bits = ^instr[31:15];

  assign ready = (state == IDLE);

  // Select byte/half/word from the read word and extend it.
  function automatic logic [31:0] extract(input logic [2:0]  f3,
                                          input logic [1:0]  off,
                                          input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[8*off +: 8];
    h = data[16*off[1] +: 16];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'd0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'd0, h};
      default: extract = data;
    endcase
  endfunction

  // Decode/illegal/misalignment checks for a load in the accepting cycle.
  logic is_alu, is_link, is_load, load_illegal, load_misaligned;
  always_comb begin
    is_alu  = (opcode == 7'b0110011) || (opcode == 7'b0010011) ||
              (opcode == 7'b0110111) || (opcode == 7'b0010111);
    is_link = (opcode == 7'b1101111) || (opcode == 7'b1100111);
    is_load = (opcode == 7'b0000011);
    load_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    load_misaligned = 1'b0;
    case (funct3)
      3'b001, 3'b101: load_misaligned = alu_result[0];
      3'b010:         load_misaligned = (alu_result[1:0] != 2'b00);
      default:        load_misaligned = 1'b0;
    endcase
  end

  // Writeback FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      write_en_3   <= 1'b0;
      mem_req      <= 1'b0;
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      rd_addr      <= 5'd0;
      write_data   <= 32'd0;
      mem_addr     <= 32'd0;
      lat_rd       <= 5'd0;
      lat_funct3   <= 3'd0;
      lat_off      <= 2'd0;
    end else begin
      write_en_3   <= 1'b0;
      misalign_err <= 1'b0;
      illegal_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            if (is_alu || is_link) begin
              write_en_3 <= (rd != 5'd0);
              rd_addr    <= rd;
              write_data <= is_alu ? alu_result : pc_plus4;
            end else if (is_load) begin
              if (load_illegal) begin
                illegal_err <= 1'b1;
              end else if (load_misaligned) begin
                misalign_err <= 1'b1;
              end else begin
                state      <= LOAD_WAIT;
                mem_req    <= 1'b1;
                mem_addr   <= {alu_result[31:2], 2'b00};
                lat_rd     <= rd;
                lat_funct3 <= funct3;
                lat_off    <= alu_result[1:0];
              end
            end
          end
        end
        LOAD_WAIT: begin
          if (mem_rvalid) begin
            state      <= LOAD_WB;
            mem_req    <= 1'b0;
            write_en_3 <= (lat_rd != 5'd0);
            rd_addr    <= lat_rd;
            write_data <= extract(lat_funct3, lat_off, mem_rdata);
          end
        end
        LOAD_WB: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, hand
// sequences for load/reset corners, and randomized requests against a
// behavioural model of the writeback rules.
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic [31:0] pc_plus4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        write_en_3;
  logic [4:0]  rd_addr;
  logic [31:0] write_data;
  logic        misalign_err;
  logic        illegal_err;

  int checks = 0;
  int errors = 0;

  regfile_writeback dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .ready(ready),
    .instr(instr), .alu_result(alu_result), .pc_plus4(pc_plus4),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .write_en_3(write_en_3), .rd_addr(rd_addr),
    .write_data(write_data), .misalign_err(misalign_err),
    .illegal_err(illegal_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [4:0] rd);
    return {17'd0, f3, rd, op};
  endfunction

  // Behavioural model. kind: 0 none, 1 direct write, 2 load, 3 misaligned, 4 illegal
  function automatic int model_kind(input logic [31:0] ins, input logic [31:0] addr);
    int op, f3, a;
    op = int'(ins[6:0]);
    f3 = int'(ins[14:12]);
    a  = int'(addr % 4);
    if (op == 'h33 || op == 'h13 || op == 'h37 || op == 'h17 ||
        op == 'h6F || op == 'h67) return 1;
    if (op != 'h03) return 0;
    if (f3 == 3 || f3 == 6 || f3 == 7) return 4;
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 3;
    if (f3 == 2 && a != 0) return 3;
    return 2;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3,
                                             input logic [31:0] addr,
                                             input logic [31:0] data);
    logic [31:0] v;
    int a;
    a = int'(addr % 4);
    case (f3)
      3'd0, 3'd4: begin
        v = (data >> (8 * a)) % 256;
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = (data >> (16 * (a / 2))) % 65536;
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = data;
    endcase
    return v;
  endfunction

  // Apply one request and check the whole transaction against the model.
  task automatic run_req(input string tag, input logic [31:0] ins,
                         input logic [31:0] alu, input logic [31:0] pc4,
                         input logic [31:0] rdata, input int wait_cycles);
    int kind;
    logic [4:0] rd;
    logic [31:0] exp;
    kind = model_kind(ins, alu);
    rd = ins[11:7];
    check({tag, "_ready"}, 32'(ready), 32'd1);
    instr_valid = 1'b1; instr = ins; alu_result = alu; pc_plus4 = pc4;
    step();
    instr_valid = 1'b0;
    if (kind == 2) begin
      for (int i = 0; i < wait_cycles; i++) begin
        check({tag, "_memreq"}, 32'(mem_req), 32'd1);
        check({tag, "_memaddr"}, mem_addr, alu & 32'hFFFF_FFFC);
        check({tag, "_busy_we"}, 32'(write_en_3), 32'd0);
        check({tag, "_busy_ready"}, 32'(ready), 32'd0);
        step();
      end
      check({tag, "_memreq_last"}, 32'(mem_req), 32'd1);
      mem_rvalid = 1'b1; mem_rdata = rdata;
      step();
      mem_rvalid = 1'b0;
      exp = model_load(ins[14:12], alu, rdata);
      check({tag, "_ld_we"}, 32'(write_en_3), 32'(rd != 0));
      check({tag, "_ld_memreq_off"}, 32'(mem_req), 32'd0);
      if (rd != 0) begin
        check({tag, "_ld_rd"}, 32'(rd_addr), 32'(rd));
        check({tag, "_ld_wd"}, write_data, exp);
      end
      step();
      check({tag, "_ld_done_we"}, 32'(write_en_3), 32'd0);
    end else begin
      check({tag, "_we"}, 32'(write_en_3), (kind == 1 && rd != 0) ? 32'd1 : 32'd0);
      if (kind == 1 && rd != 0) begin
        check({tag, "_rd"}, 32'(rd_addr), 32'(rd));
        exp = (ins[6:0] == 7'h6F || ins[6:0] == 7'h67) ? pc4 : alu;
        check({tag, "_wd"}, write_data, exp);
      end
      check({tag, "_mis"}, 32'(misalign_err), 32'(kind == 3));
      check({tag, "_ill"}, 32'(illegal_err), 32'(kind == 4));
      check({tag, "_memreq"}, 32'(mem_req), 32'd0);
      step();
      check({tag, "_pulse_end"}, {30'd0, misalign_err, illegal_err}, 32'd0);
      check({tag, "_we_end"}, 32'(write_en_3), 32'd0);
    end
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [31:0] alu;
    logic [31:0] pc4;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [6:0] ops[8];
    logic [2:0] f3s[8];
    int we_seen;

    reset = 1'b1; instr_valid = 1'b0; instr = '0; alu_result = '0;
    pc_plus4 = '0; mem_rdata = '0; mem_rvalid = 1'b0;
    step(); step();
    check("rst_we", 32'(write_en_3), 32'd0);
    check("rst_memreq", 32'(mem_req), 32'd0);
    check("rst_errs", {30'd0, misalign_err, illegal_err}, 32'd0);
    check("rst_rd", 32'(rd_addr), 32'd0);
    check("rst_wd", write_data, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    reset = 1'b0;
    check("ready_after_rst", 32'(ready), 32'd1);

    // Directed table: ALU/link writes, no-write opcodes, dropped loads.
    vecs[0] = '{32'h00A28293, 32'h0000000F, 32'h0};          // ADDI x5
    vecs[1] = '{mk(7'h6F, 3'd0, 5'd1), 32'h0, 32'h00000104}; // JAL x1
    vecs[2] = '{mk(7'h6F, 3'd0, 5'd0), 32'h0, 32'h00000104}; // JAL x0
    vecs[3] = '{mk(7'h37, 3'd0, 5'd10), 32'h12345000, 32'h0}; // LUI
    vecs[4] = '{mk(7'h67, 3'd0, 5'd3), 32'h1, 32'h00000200}; // JALR
    vecs[5] = '{mk(7'h23, 3'd2, 5'd5), 32'h100, 32'h0};      // store: none
    vecs[6] = '{mk(7'h03, 3'd2, 5'd4), 32'h00000102, 32'h0}; // LW misaligned
    vecs[7] = '{mk(7'h03, 3'd3, 5'd4), 32'h00000100, 32'h0}; // funct3 011
    vecs[8] = '{mk(7'h03, 3'd1, 5'd6), 32'h00000101, 32'h0}; // LH misaligned
    vecs[9] = '{mk(7'h17, 3'd0, 5'd2), 32'hDEAD0000, 32'h0}; // AUIPC
    for (int i = 0; i < 10; i++)
      run_req($sformatf("vec%0d", i), vecs[i].ins, vecs[i].alu, vecs[i].pc4, 32'h0, 0);

    // LB / LBU with three wait cycles.
    run_req("lb", mk(7'h03, 3'd0, 5'd7), 32'h00000103, 32'h0, 32'h80FF1234, 2);
    run_req("lbu", mk(7'h03, 3'd4, 5'd7), 32'h00000103, 32'h0, 32'h80FF1234, 2);

    // Stray mem_rvalid while idle is ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFFFFFF;
    step();
    mem_rvalid = 1'b0;
    check("idle_rvalid_we", 32'(write_en_3), 32'd0);
    check("idle_rvalid_ready", 32'(ready), 32'd1);

    // Reset in LOAD_WAIT together with mem_rvalid.
    instr_valid = 1'b1; instr = mk(7'h03, 3'd2, 5'd9); alu_result = 32'h40;
    step();
    instr_valid = 1'b0;
    check("rstw_memreq_pre", 32'(mem_req), 32'd1);
    reset = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    step();
    reset = 1'b0; mem_rvalid = 1'b0;
    check("rstw_memreq", 32'(mem_req), 32'd0);
    check("rstw_we", 32'(write_en_3), 32'd0);
    check("rstw_ready", 32'(ready), 32'd1);
    we_seen = 0;
    for (int i = 0; i < 3; i++) begin step(); we_seen += int'(write_en_3); end
    check("rstw_no_late_we", 32'(we_seen), 32'd0);

    // Three back-to-back ADDs, one write pulse each.
    for (int i = 1; i <= 3; i++) begin
      instr_valid = 1'b1; instr = mk(7'h33, 3'd0, 5'(i)); alu_result = 32'(i * 100);
      step();
      check($sformatf("b2b%0d_we", i), 32'(write_en_3), 32'd1);
      check($sformatf("b2b%0d_rd", i), 32'(rd_addr), 32'(i));
      check($sformatf("b2b%0d_wd", i), write_data, 32'(i * 100));
    end
    // Load accepted, then a second load offered while busy is dropped.
    instr = mk(7'h03, 3'd2, 5'd8); alu_result = 32'h200;
    step();
    check("blk_b2b_end_we", 32'(write_en_3), 32'd0);
    instr = mk(7'h03, 3'd2, 5'd11); alu_result = 32'h300;
    for (int i = 0; i < 2; i++) begin
      check("blk_ready", 32'(ready), 32'd0);
      check("blk_addr", mem_addr, 32'h200);
      step();
    end
    instr_valid = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    step();
    mem_rvalid = 1'b0;
    check("blk_we", 32'(write_en_3), 32'd1);
    check("blk_rd", 32'(rd_addr), 32'd8);
    check("blk_wd", write_data, 32'hCAFEF00D);
    we_seen = 0;
    for (int i = 0; i < 3; i++) begin step(); we_seen += int'(mem_req) + int'(write_en_3); end
    check("blk_dropped", 32'(we_seen), 32'd0);

    // Randomized requests against the model.
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h63};
    f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd2, 3'd7};
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      logic [2:0] f3;
      op = (n % 3 == 0) ? 7'h03 : ops[$urandom_range(0, 7)];
      f3 = f3s[$urandom_range(0, 7)];
      if ($urandom_range(0, 9) == 0) f3 = 3'(6 - $urandom_range(0, 1) * 3);
      run_req($sformatf("rnd%0d", n), mk(op, f3, 5'($urandom_range(0, 31))),
              $urandom, $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
